// File: rtl/radar_calibration_sequencer.sv
// Radar interface calibration sequencer: synchronizes ARP/ACP/TRIG, measures
// per-revolution statistics and locks after STABLE_REVS matching revolutions.
module radar_calibration_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CLK_PER_US  = 100,
  parameter int unsigned STABLE_REVS = 2,
  parameter int unsigned US_TOL      = 2,
  parameter int unsigned TIMEOUT_US  = 20000000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ARP,
  input  logic                  ACP,
  input  logic                  TRIG,
  input  logic                  START,
  input  logic                  ABORT,
  output logic [DATA_WIDTH-1:0] ARP_US,
  output logic [DATA_WIDTH-1:0] ACP_CNT,
  output logic [DATA_WIDTH-1:0] TRIG_CNT,
  output logic                  CALIBRATED,
  output logic                  BUSY,
  output logic                  ERROR,
  output logic [2:0]            STATE
);

  localparam int unsigned PRESC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_MAX  = PRESC_W'(CLK_PER_US - 1);
  localparam logic [PRESC_W-1:0]    PRESC_ONE  = PRESC_W'(1);
  localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] TOL        = DATA_WIDTH'(US_TOL);
  localparam logic [DATA_WIDTH-1:0] TIMEOUT    = DATA_WIDTH'(TIMEOUT_US);
  localparam logic [3:0]            STABLE_CNT = 4'(STABLE_REVS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    MEASURE = 3'd2,
    LOCKED  = 3'd3,
    FAULT   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [2:0]            arp_sync_q, arp_sync_d;
  logic [2:0]            acp_sync_q, acp_sync_d;
  logic [2:0]            trig_sync_q, trig_sync_d;
  logic                  arp_e, acp_e, trig_e;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  us_tick;

  logic [DATA_WIDTH-1:0] us_run_q, us_run_d;
  logic [DATA_WIDTH-1:0] acp_run_q, acp_run_d;
  logic [DATA_WIDTH-1:0] trig_run_q, trig_run_d;
  logic [DATA_WIDTH-1:0] trig_last_q, trig_last_d;

  logic [DATA_WIDTH-1:0] arp_us_q, arp_us_d;
  logic [DATA_WIDTH-1:0] acp_cnt_q, acp_cnt_d;
  logic [DATA_WIDTH-1:0] trig_cnt_q, trig_cnt_d;
  logic [3:0]            match_cnt_q, match_cnt_d;
  logic                  calibrated_q, calibrated_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  logic [DATA_WIDTH-1:0] us_diff;
  logic                  cand_sat, cand_match, timeout, publish, clear_run;
  logic [3:0]            match_inc, cnt_next;

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // Input synchronizers; bit 2 is the edge-detect history stage.
  always_comb begin
    arp_sync_d  = {arp_sync_q[1:0], ARP};
    acp_sync_d  = {acp_sync_q[1:0], ACP};
    trig_sync_d = {trig_sync_q[1:0], TRIG};
  end

  assign arp_e  = arp_sync_q[1]  & ~arp_sync_q[2];
  assign acp_e  = acp_sync_q[1]  & ~acp_sync_q[2];
  assign trig_e = trig_sync_q[1] & ~trig_sync_q[2];

  assign us_tick = (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = us_tick ? '0 : presc_q + PRESC_ONE;
  end

  // Candidate revolution is {us_run, acp_run, trig_last} as held when arp_e fires.
  always_comb begin
    us_diff    = (us_run_q >= arp_us_q) ? (us_run_q - arp_us_q) : (arp_us_q - us_run_q);
    cand_sat   = (&us_run_q) | (&acp_run_q) | (&trig_last_q);
    cand_match = !cand_sat && (us_diff <= TOL) &&
                 (acp_run_q == acp_cnt_q) && (trig_last_q == trig_cnt_q);
    timeout    = (us_run_q >= TIMEOUT);
    match_inc  = (match_cnt_q == 4'hF) ? match_cnt_q : match_cnt_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    publish     = 1'b0;
    cnt_next    = 4'd1;
    if (ABORT) begin
      state_d     = IDLE;
      match_cnt_d = '0;
    end else if (timeout && (state_q == SYNC || state_q == MEASURE || state_q == LOCKED)) begin
      state_d = FAULT;
    end else begin
      unique case (state_q)
        IDLE, FAULT: begin
          if (START) begin
            state_d     = SYNC;
            match_cnt_d = '0;
          end
        end
        SYNC: begin
          if (arp_e) state_d = MEASURE;
        end
        MEASURE: begin
          if (arp_e) begin
            publish     = 1'b1;
            cnt_next    = cand_match ? match_inc : 4'd1;
            match_cnt_d = cnt_next;
            if (cnt_next >= STABLE_CNT) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (arp_e) begin
            publish = 1'b1;
            if (!cand_match) begin
              state_d     = MEASURE;
              match_cnt_d = 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    calibrated_d = (state_d == LOCKED);
    busy_d       = (state_d == SYNC) || (state_d == MEASURE);
    error_d      = (state_d == FAULT);
  end

  // Counters restart whenever a fresh calibration begins, including retry from FAULT.
  assign clear_run = (state_d == IDLE) || ((state_d == SYNC) && (state_q != SYNC));

  always_comb begin
    us_run_d    = us_tick ? sat_inc(us_run_q) : us_run_q;
    acp_run_d   = acp_e ? sat_inc(acp_run_q) : acp_run_q;
    trig_run_d  = trig_e ? sat_inc(trig_run_q) : trig_run_q;
    trig_last_d = trig_last_q;
    if (acp_e) begin
      trig_last_d = trig_run_q;
      trig_run_d  = trig_e ? ONE : '0;
    end
    if (arp_e) begin
      us_run_d  = us_tick ? ONE : '0;
      acp_run_d = acp_e ? ONE : '0;
    end
    if (clear_run) begin
      us_run_d    = '0;
      acp_run_d   = '0;
      trig_run_d  = '0;
      trig_last_d = '0;
    end
  end

  always_comb begin
    arp_us_d   = publish ? us_run_q    : arp_us_q;
    acp_cnt_d  = publish ? acp_run_q   : acp_cnt_q;
    trig_cnt_d = publish ? trig_last_q : trig_cnt_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      arp_sync_q  <= '0;
      acp_sync_q  <= '0;
      trig_sync_q <= '0;
      presc_q     <= '0;
      us_run_q    <= '0;
      acp_run_q   <= '0;
      trig_run_q  <= '0;
      trig_last_q <= '0;
      match_cnt_q <= '0;
    end else begin
      arp_sync_q  <= arp_sync_d;
      acp_sync_q  <= acp_sync_d;
      trig_sync_q <= trig_sync_d;
      presc_q     <= presc_d;
      us_run_q    <= us_run_d;
      acp_run_q   <= acp_run_d;
      trig_run_q  <= trig_run_d;
      trig_last_q <= trig_last_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      arp_us_q     <= '0;
      acp_cnt_q    <= '0;
      trig_cnt_q   <= '0;
      calibrated_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      arp_us_q     <= arp_us_d;
      acp_cnt_q    <= acp_cnt_d;
      trig_cnt_q   <= trig_cnt_d;
      calibrated_q <= calibrated_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign ARP_US     = arp_us_q;
  assign ACP_CNT    = acp_cnt_q;
  assign TRIG_CNT   = trig_cnt_q;
  assign CALIBRATED = calibrated_q;
  assign BUSY       = busy_q;
  assign ERROR      = error_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_radar_calibration_sequencer.sv
// Bench for radar_calibration_sequencer: scripted and randomized revolutions
// checked every cycle against an event-window reference model.
module tb_radar_calibration_sequencer;

  localparam int DW    = 32;
  localparam int CPU   = 4;
  localparam int SREVS = 2;
  localparam int TOL   = 2;
  localparam int TMO   = 500;

  localparam int S_IDLE   = 0;
  localparam int S_SYNC   = 1;
  localparam int S_MEAS   = 2;
  localparam int S_LOCKED = 3;
  localparam int S_FAULT  = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          ARP = 1'b0, ACP = 1'b0, TRIG = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic [DW-1:0] ARP_US, ACP_CNT, TRIG_CNT;
  logic          CALIBRATED, BUSY, ERROR;
  logic [2:0]    STATE;

  radar_calibration_sequencer #(
    .DATA_WIDTH (DW),
    .CLK_PER_US (CPU),
    .STABLE_REVS(SREVS),
    .US_TOL     (TOL),
    .TIMEOUT_US (TMO)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ARP       (ARP),
    .ACP       (ACP),
    .TRIG      (TRIG),
    .START     (START),
    .ABORT     (ABORT),
    .ARP_US    (ARP_US),
    .ACP_CNT   (ACP_CNT),
    .TRIG_CNT  (TRIG_CNT),
    .CALIBRATED(CALIBRATED),
    .BUSY      (BUSY),
    .ERROR     (ERROR),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: statistics are counts of events inside cycle windows.
  int     m_state, m_cnt;
  longint m_us, m_acp, m_trig;
  longint n;
  longint us_start, acp_tot, acp_start, trig_tot, trig_start, trig_last;
  bit     arp_h[4], acp_h[4], trig_h[4];

  function automatic longint ticks_in(input longint a, input longint b);
    if (b < a) return 0;
    return b / CPU - (a - 1) / CPU;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_cnt = 0;
    m_us = 0; m_acp = 0; m_trig = 0;
    n = 0; us_start = 1;
    acp_tot = 0; acp_start = 0; trig_tot = 0; trig_start = 0; trig_last = 0;
    for (int i = 0; i < 4; i++) begin
      arp_h[i] = 1'b0; acp_h[i] = 1'b0; trig_h[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit st, input bit ab);
    bit     e_arp, e_acp, e_trig, matched, pub, restart;
    longint c_us, c_acp, c_trig, diff;
    int     nxt;
    e_arp  = arp_h[2]  && !arp_h[3];
    e_acp  = acp_h[2]  && !acp_h[3];
    e_trig = trig_h[2] && !trig_h[3];
    c_us   = ticks_in(us_start, n - 1);
    c_acp  = acp_tot - acp_start;
    c_trig = trig_last;
    diff   = c_us - m_us;
    if (diff < 0) diff = -diff;
    matched = (diff <= TOL) && (c_acp == m_acp) && (c_trig == m_trig);
    nxt = m_state;
    pub = 1'b0;
    if (ab) begin
      nxt = S_IDLE; m_cnt = 0;
    end else if (m_state >= S_SYNC && m_state <= S_LOCKED && c_us >= TMO) begin
      nxt = S_FAULT;
    end else if ((m_state == S_IDLE || m_state == S_FAULT) && st) begin
      nxt = S_SYNC; m_cnt = 0;
    end else if (e_arp && m_state == S_SYNC) begin
      nxt = S_MEAS;
    end else if (e_arp && m_state == S_MEAS) begin
      pub = 1'b1;
      m_cnt = matched ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
      if (m_cnt >= SREVS) nxt = S_LOCKED;
    end else if (e_arp && m_state == S_LOCKED) begin
      pub = 1'b1;
      if (!matched) begin
        nxt = S_MEAS; m_cnt = 1;
      end
    end
    if (pub) begin
      m_us = c_us; m_acp = c_acp; m_trig = c_trig;
    end
    restart = (nxt == S_IDLE) || (nxt == S_SYNC && m_state != S_SYNC);
    if (restart) begin
      us_start   = n + 1;
      acp_start  = acp_tot + e_acp;
      trig_start = trig_tot + e_trig;
      trig_last  = 0;
    end else begin
      if (e_acp) begin
        trig_last  = trig_tot - trig_start;
        trig_start = trig_tot;
      end
      if (e_arp) begin
        us_start  = n;
        acp_start = acp_tot;
      end
    end
    acp_tot  += e_acp;
    trig_tot += e_trig;
    m_state = nxt;
  endtask

  task automatic check_outputs();
    check_eq("STATE", STATE, m_state);
    check_eq("CALIBRATED", CALIBRATED, m_state == S_LOCKED);
    check_eq("BUSY", BUSY, (m_state == S_SYNC) || (m_state == S_MEAS));
    check_eq("ERROR", ERROR, m_state == S_FAULT);
    check_eq("ARP_US", ARP_US, m_us);
    check_eq("ACP_CNT", ACP_CNT, m_acp);
    check_eq("TRIG_CNT", TRIG_CNT, m_trig);
  endtask

  // Called just after a falling edge: drive, clock, model, then compare.
  task automatic cycle(input bit a, input bit c, input bit t, input bit st, input bit ab);
    ARP = a; ACP = c; TRIG = t; START = st; ABORT = ab;
    @(posedge CLK);
    n++;
    for (int i = 3; i > 0; i--) begin
      arp_h[i] = arp_h[i-1]; acp_h[i] = acp_h[i-1]; trig_h[i] = trig_h[i-1];
    end
    arp_h[0] = a; acp_h[0] = c; trig_h[0] = t;
    model_step(st, ab);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_rev(input int clks, input int nacp, input int tpa,
                         input bit acp_co, input bit trig_co);
    int spacing, acp_off, trel, tstep, ap, tp;
    bit a, p, t;
    spacing = clks / nacp;
    acp_off = acp_co ? 0 : spacing / 2;
    trel    = trig_co ? 0 : 3;
    tstep   = spacing / tpa;
    for (int c = 0; c < clks; c++) begin
      a = (c < 2);
      p = 1'b0;
      t = 1'b0;
      for (int j = 0; j < nacp; j++) begin
        ap = acp_off + j * spacing;
        if (c == ap || c == ap + 1) p = 1'b1;
        for (int i = 0; i < tpa; i++) begin
          tp = ap + trel + i * tstep;
          if ((tp + 1 < clks) && (c == tp || c == tp + 1)) t = 1'b1;
        end
      end
      cycle(a, p, t, 1'b0, 1'b0);
    end
  endtask

  task automatic release_reset();
    RST_N = 1'b0;
    ARP = 1'b0; ACP = 1'b0; TRIG = 1'b0; START = 1'b0; ABORT = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    int clks, nacp, tpa;
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    @(negedge CLK);
    release_reset();
    idle(8);
    check_eq("reset_state", STATE, 0);
    check_eq("reset_arp_us", ARP_US, 0);
    check_eq("reset_busy", BUSY, 0);

    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("start_sync", STATE, S_SYNC);
    idle(5);

    repeat (4) run_rev(400, 10, 3, 1'b0, 1'b0);
    check_eq("lock_state", STATE, S_LOCKED);
    check_eq("lock_cal", CALIBRATED, 1);
    check_eq("lock_arp_us", ARP_US, 100);
    check_eq("lock_acp", ACP_CNT, 10);
    check_eq("lock_trig", TRIG_CNT, 3);

    run_rev(400, 11, 3, 1'b0, 1'b0);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    check_eq("acp11_state", STATE, S_MEAS);
    check_eq("acp11_cal", CALIBRATED, 0);
    check_eq("acp11_cnt", ACP_CNT, 11);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    check_eq("relock_state", STATE, S_LOCKED);

    run_rev(408, 10, 3, 1'b0, 1'b0);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    run_rev(392, 10, 3, 1'b0, 1'b0);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    check_eq("jitter_state", STATE, S_LOCKED);
    run_rev(412, 10, 3, 1'b0, 1'b0);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    check_eq("jit103_state", STATE, S_MEAS);
    check_eq("jit103_us", ARP_US, 103);

    repeat (4) run_rev(400, 10, 3, 1'b1, 1'b1);
    check_eq("coinc_state", STATE, S_LOCKED);
    check_eq("coinc_acp", ACP_CNT, 10);
    check_eq("coinc_trig", TRIG_CNT, 3);

    idle(2200);
    check_eq("tmo_state", STATE, S_FAULT);
    check_eq("tmo_error", ERROR, 1);
    check_eq("tmo_hold_us", ARP_US, 100);
    check_eq("tmo_hold_acp", ACP_CNT, 10);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("fault_restart", STATE, S_SYNC);
    idle(3);

    for (int r = 0; r < 20; r++) begin
      clks = 392 + 4 * $urandom_range(5);
      nacp = ($urandom_range(5) == 0) ? 11 : 10;
      tpa  = ($urandom_range(4) == 0) ? 2 : 3;
      run_rev(clks, nacp, tpa, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("abort_wins", STATE, S_IDLE);
    idle(4);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    run_rev(400, 10, 3, 1'b0, 1'b0);
    idle(50);
    check_eq("pre_rst_state", STATE, S_MEAS);

    #2 RST_N = 1'b0;
    #1;
    check_eq("arst_state", STATE, 0);
    check_eq("arst_arp_us", ARP_US, 0);
    check_eq("arst_acp", ACP_CNT, 0);
    check_eq("arst_trig", TRIG_CNT, 0);
    check_eq("arst_busy", BUSY, 0);
    release_reset();
    idle(10);
    check_eq("post_rst_state", STATE, S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
